// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants and timeout-FSM encoding for the UART receive controller.
// Default timeout is four character times at the nominal bit rate.
package uart_rx_ctrl_pkg;
   localparam int RX_CLOCK_MUL       = 868;
   localparam int BITS_PER_CHAR      = 10;
   localparam int DEF_DEPTH_LOG2     = 4;
   localparam int DEF_TIMEOUT_CYCLES = 4 * RX_CLOCK_MUL * BITS_PER_CHAR;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_EXP  = 2'd2
   } tmo_state_e;

   // Idle counter is at least 16 bits, wider only if the timeout needs it.
   function automatic int tc_width(input int cycles);
      return ($clog2(cycles) > 16) ? $clog2(cycles) : 16;
   endfunction
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and CPU-side signals of the receive controller.
// slave is the controller's view, master the driving environment's view.
interface uart_rx_ctrl_if
   import uart_rx_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_DEPTH_LOG2 + 1
) ();
   logic [7:0]       rx_data;
   logic             rx_received;
   logic             rd_strobe;
   logic             clr_ovr;
   logic             irq_en;
   logic [CNT_W-1:0] irq_thresh;
   logic [7:0]       dout;
   logic             dout_valid;
   logic [CNT_W-1:0] fifo_count;
   logic             empty;
   logic             full;
   logic             overrun;
   logic             timeout;
   logic             irq;

   modport slave (
      input  rx_data, rx_received, rd_strobe, clr_ovr, irq_en, irq_thresh,
      output dout, dout_valid, fifo_count, empty, full, overrun, timeout, irq
   );

   modport master (
      output rx_data, rx_received, rd_strobe, clr_ovr, irq_en, irq_thresh,
      input  dout, dout_valid, fifo_count, empty, full, overrun, timeout, irq
   );
endinterface

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// Byte FIFO with registered count/flags and a registered read port.
// A pop on a full FIFO frees the slot for a write in the same cycle.
module sync_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int CNT_W      = DEPTH_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [7:0]       wdata_i,
   input  logic             rd_i,
   output logic             rd_ok_o,
   output logic [7:0]       dout_o,
   output logic             dout_valid_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int               DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  empty_q, full_q;
   logic [7:0]            dout_q;
   logic                  dout_valid_q;
   logic                  rd_ok, wr_ok;

   assign rd_ok = rd_i & ~empty_q;
   assign wr_ok = wr_i & (~full_q | rd_ok);

   always_comb begin
      count_d = count_q;
      if (wr_ok && !rd_ok)
         count_d = count_q + CNT_W'(1);
      else if (!wr_ok && rd_ok)
         count_d = count_q - CNT_W'(1);
   end

   // Storage has no reset; contents are meaningless once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (rd_ok) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            dout_q   <= mem_q[rd_ptr_q];
         end
         dout_valid_q <= rd_ok;
         count_q      <= count_d;
         empty_q      <= (count_d == '0);
         full_q       <= (count_d == DEPTH_C);
      end
   end

   assign rd_ok_o      = rd_ok;
   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign count_o      = count_q;
   assign empty_o      = empty_q;
   assign full_o       = full_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte capture into a FIFO, sticky overrun,
// idle-line timeout and a single registered interrupt.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic            clk,
   input logic            rst,
   uart_rx_ctrl_if.slave  bus
);
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int TC_W  = tc_width(TIMEOUT_CYCLES);
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);

   logic             rx_prev_q;
   logic             wr_ev, rd_ok, activity;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty, fifo_full;
   logic             overrun_q, overrun_d;
   logic             irq_q, irq_d;
   tmo_state_e       state_q, state_d;
   logic [TC_W-1:0]  tc_q, tc_d;

   // A held rx_received counts once: only its rising edge writes.
   assign wr_ev = bus.rx_received & ~rx_prev_q;

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .wr_i         (wr_ev),
      .wdata_i      (bus.rx_data),
      .rd_i         (bus.rd_strobe),
      .rd_ok_o      (rd_ok),
      .dout_o       (bus.dout),
      .dout_valid_o (bus.dout_valid),
      .count_o      (fifo_count),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full)
   );

   assign activity  = wr_ev | rd_ok;
   // Set beats clear when both land in the same cycle.
   assign overrun_d = (wr_ev & fifo_full & ~rd_ok) | (overrun_q & ~bus.clr_ovr);

   always_comb begin
      state_d = state_q;
      tc_d    = tc_q;
      if (fifo_empty) begin
         state_d = T_IDLE;
         tc_d    = '0;
      end else begin
         case (state_q)
            T_IDLE: begin
               state_d = T_RUN;
               tc_d    = '0;
            end
            T_RUN: begin
               if (activity)
                  tc_d = '0;
               else if (tc_q == TC_LAST)
                  state_d = T_EXP;
               else
                  tc_d = tc_q + TC_W'(1);
            end
            T_EXP: begin
               if (activity) begin
                  state_d = T_RUN;
                  tc_d    = '0;
               end
            end
            default: begin
               state_d = T_IDLE;
               tc_d    = '0;
            end
         endcase
      end
   end

   assign irq_d = bus.irq_en &
                  (((bus.irq_thresh != '0) && (fifo_count >= bus.irq_thresh)) |
                   (state_q == T_EXP) | overrun_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_prev_q <= 1'b0;
         overrun_q <= 1'b0;
         irq_q     <= 1'b0;
         state_q   <= T_IDLE;
         tc_q      <= '0;
      end else begin
         rx_prev_q <= bus.rx_received;
         overrun_q <= overrun_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
         tc_q      <= tc_d;
      end
   end

   assign bus.fifo_count = fifo_count;
   assign bus.empty      = fifo_empty;
   assign bus.full       = fifo_full;
   assign bus.overrun    = overrun_q;
   assign bus.timeout    = (state_q == T_EXP);
   assign bus.irq        = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and random stimulus for uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;
   import uart_rx_ctrl_pkg::*;

   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int CW    = 5;
   localparam int TMO   = DEF_TIMEOUT_CYCLES;

   logic clk = 1'b0;
   logic rst;

   uart_rx_ctrl_if #(.CNT_W(CW)) bif ();

   uart_rx_ctrl #(
      .DEPTH_LOG2     (DL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] mq[$];
   bit         m_ovr, m_prev, m_tmo;
   logic [7:0] m_dout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b0;
      m_tmo  = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic drive_idle();
      bif.rx_received = 1'b0;
      bif.rx_data     = 8'bz;
      bif.rd_strobe   = 1'b0;
      bif.clr_ovr     = 1'b0;
   endtask

   // One clock: apply inputs, advance the model, compare every output.
   task automatic cyc(input bit rx, input logic [7:0] d, input bit rd, input bit clr);
      bit wr, rd_ok, ovf, irq_e;
      int sz;
      bif.rx_received = rx;
      bif.rx_data     = rx ? d : 8'bz;
      bif.rd_strobe   = rd;
      bif.clr_ovr     = clr;
      wr     = rx & ~m_prev;
      m_prev = rx;
      sz     = mq.size();
      irq_e  = bif.irq_en & (((bif.irq_thresh != 0) && (sz >= int'(bif.irq_thresh))) | m_tmo | m_ovr);
      rd_ok  = rd && (sz > 0);
      if (rd_ok) m_dout = mq.pop_front();
      ovf = 1'b0;
      if (wr) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else ovf = 1'b1;
      end
      m_ovr = ovf ? 1'b1 : (clr ? 1'b0 : m_ovr);
      if (wr || rd_ok || mq.size() == 0) m_tmo = 1'b0;
      @(posedge clk); #1;
      chk("count",      bif.fifo_count, mq.size());
      chk("empty",      bif.empty,      mq.size() == 0);
      chk("full",       bif.full,       mq.size() == DEPTH);
      chk("overrun",    bif.overrun,    m_ovr);
      chk("dout_valid", bif.dout_valid, rd_ok);
      chk("dout",       bif.dout,       m_dout);
      chk("timeout",    bif.timeout,    m_tmo);
      chk("irq",        bif.irq,        irq_e);
   endtask

   task automatic wr_byte(input logic [7:0] d);
      cyc(1'b1, d, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_count"},   bif.fifo_count, 0);
      chk({tag, "_empty"},   bif.empty,      1);
      chk({tag, "_full"},    bif.full,       0);
      chk({tag, "_overrun"}, bif.overrun,    0);
      chk({tag, "_timeout"}, bif.timeout,    0);
      chk({tag, "_irq"},     bif.irq,        0);
      chk({tag, "_dout"},    bif.dout,       0);
      chk({tag, "_dvalid"},  bif.dout_valid, 0);
   endtask

   initial begin
      int first;
      rst            = 1'b1;
      bif.irq_en     = 1'b0;
      bif.irq_thresh = '0;
      drive_idle();
      model_reset();
      #2 rst = 1'b0;
      #1 reset_checks("rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Basic write/read ordering
      wr_byte(8'h41); wr_byte(8'h42); wr_byte(8'h43);
      chk("three_count", bif.fifo_count, 3);
      repeat (3) pop();
      chk("three_empty", bif.empty, 1);
      pop();

      // Held rx_received yields a single entry
      repeat (5) cyc(1'b1, 8'h55, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("held_count", bif.fifo_count, 1);
      pop();

      // Fill, overrun, clear
      for (int i = 0; i < 17; i++) wr_byte(8'(i));
      chk("ovr_set", bif.overrun, 1);
      pop();
      chk("ovr_pop0", bif.dout, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovr_clr", bif.overrun, 0);
      repeat (15) pop();

      // Write and pop together on a full FIFO
      for (int i = 0; i < 16; i++) wr_byte(8'h10 + 8'(i));
      cyc(1'b1, 8'hAA, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("fullrw_count", bif.fifo_count, 16);
      chk("fullrw_ovr",   bif.overrun,    0);
      repeat (16) pop();
      chk("fullrw_last",  bif.dout, 8'hAA);

      // Threshold interrupt
      bif.irq_en     = 1'b1;
      bif.irq_thresh = 5'd4;
      repeat (3) wr_byte(8'h60);
      chk("thr_below", bif.irq, 0);
      wr_byte(8'h61);
      chk("thr_hit", bif.irq, 1);
      pop();
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("thr_drop", bif.irq, 0);
      repeat (3) pop();

      // Idle-line timeout
      bif.irq_thresh = '0;
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      drive_idle();
      first = -1;
      for (int k = 1; k <= TMO + 10; k++) begin
         @(posedge clk); #1;
         if (bif.timeout && first < 0) begin
            first = k;
            break;
         end
      end
      chk("tmo_window", (first >= TMO - 2) && (first <= TMO + 4), 1);
      @(posedge clk); #1;
      chk("tmo_irq", bif.irq, 1);
      m_tmo = 1'b1;
      pop();
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("tmo_clear", bif.timeout, 0);
      chk("tmo_irq_clear", bif.irq, 0);

      // Random traffic
      bif.irq_en = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            bif.irq_en     = 1'($urandom);
            bif.irq_thresh = CW'($urandom_range(0, DEPTH));
         end
         cyc(1'($urandom), 8'($urandom), $urandom_range(0, 9) < 4,
             $urandom_range(0, 24) == 0);
      end
      while (mq.size() > 0) pop();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset in the middle of operation
      bif.irq_en     = 1'b1;
      bif.irq_thresh = 5'd2;
      repeat (3) wr_byte(8'h90);
      chk("mid_irq_pre", bif.irq, 1);
      rst = 1'b0;
      #1 reset_checks("midrst");
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      wr_byte(8'h5A);
      pop();
      chk("post_rst_dout", bif.dout, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
